// File: rtl/rv32i_control_if.sv
// Memory-side signals of the RV32I multicycle controller.
// A request (mem_read or mem_write) is held steady until the cycle mem_resp pulses high; the controller then moves on.
interface rv32i_control_if;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_byte_enable;
    logic [1:0] mem_addr_lo;
    logic       mem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable,
        input  mem_addr_lo, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable,
        output mem_addr_lo, mem_resp
    );
endinterface

// File: rtl/rv32i_control.sv
// Multicycle RV32I control FSM: fetch, decode and per-class execute states.
// Drives the datapath enables, mux selects, ALU/compare operations and memory requests.
module rv32i_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       br_en,
    rv32i_control_if.master mem,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_regfile,
    output logic       load_mar,
    output logic       load_mdr,
    output logic       load_data_out,
    output logic       pcmux_sel,
    output logic       alumux1_sel,
    output logic [2:0] alumux2_sel,
    output logic [3:0] regfilemux_sel,
    output logic       marmux_sel,
    output logic       cmpmux_sel,
    output logic [2:0] aluop,
    output logic [2:0] cmpop,
    output logic [3:0] state_dbg
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    localparam logic       PC_PLUS4 = 1'b0, PC_ALU = 1'b1;
    localparam logic       A1_RS1 = 1'b0, A1_PC = 1'b1;
    localparam logic [2:0] A2_I = 3'd0, A2_U = 3'd1, A2_B = 3'd2, A2_S = 3'd3, A2_J = 3'd4, A2_RS2 = 3'd5;
    localparam logic [3:0] RF_ALU = 4'd0, RF_BR = 4'd1, RF_U = 4'd2, RF_LW = 4'd3, RF_PC4 = 4'd4,
                           RF_LB = 4'd5, RF_LBU = 4'd6, RF_LH = 4'd7, RF_LHU = 4'd8;
    localparam logic       MAR_PC = 1'b0, MAR_ALU = 1'b1;
    localparam logic       CMP_RS2 = 1'b0, CMP_I = 1'b1;
    // ALU encoding lines up with funct3 for add/sll/xor/srl/or/and, so funct3 can pass through.
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SRA = 3'd2, ALU_SUB = 3'd3;
    localparam logic [2:0] F3_ADD = 3'b000, F3_SLT = 3'b010, F3_SLTU = 3'b011, F3_SR = 3'b101;
    localparam logic [2:0] CMP_BLT = 3'b100, CMP_BLTU = 3'b110;

    typedef enum logic [3:0] {
        FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC,
        BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2
    } state_t;

    state_t state, next_state;
    logic   unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH1;
        else      state <= next_state;
    end

    always_comb begin
        next_state          = state;
        load_pc             = 1'b0;
        load_ir             = 1'b0;
        load_regfile        = 1'b0;
        load_mar            = 1'b0;
        load_mdr            = 1'b0;
        load_data_out       = 1'b0;
        mem.mem_read        = 1'b0;
        mem.mem_write       = 1'b0;
        mem.mem_byte_enable = 4'b1111;
        pcmux_sel           = PC_PLUS4;
        alumux1_sel         = A1_RS1;
        alumux2_sel         = A2_I;
        regfilemux_sel      = RF_ALU;
        marmux_sel          = MAR_PC;
        cmpmux_sel          = CMP_RS2;
        aluop               = ALU_ADD;
        cmpop               = funct3;
        // Held in reset the state already reads FETCH1; keep every output at its default meanwhile.
        if (rst) begin
            case (state)
                FETCH1: begin
                    load_mar   = 1'b1;
                    next_state = FETCH2;
                end
                FETCH2: begin
                    mem.mem_read = 1'b1;
                    load_mdr     = 1'b1;
                    if (mem.mem_resp) next_state = FETCH3;
                end
                FETCH3: begin
                    load_ir    = 1'b1;
                    next_state = DECODE;
                end
                DECODE: begin
                    case (opcode)
                        OP_IMM:             next_state = IMM;
                        OP_REG:             next_state = REG;
                        OP_LUI:             next_state = LUI;
                        OP_AUIPC:           next_state = AUIPC;
                        OP_BR:              next_state = BR;
                        OP_JAL:             next_state = JAL;
                        OP_JALR:            next_state = JALR;
                        OP_LOAD, OP_STORE:  next_state = CALC_ADDR;
                        default:            next_state = FETCH1;
                    endcase
                end
                IMM, REG: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    if (state == REG) alumux2_sel = A2_RS2;
                    if (funct3 == F3_SLT || funct3 == F3_SLTU) begin
                        cmpmux_sel     = (state == REG) ? CMP_RS2 : CMP_I;
                        cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                        regfilemux_sel = RF_BR;
                    end else if (funct3 == F3_SR && funct7[5]) begin
                        aluop = ALU_SRA;
                    end else if (state == REG && funct3 == F3_ADD && funct7[5]) begin
                        aluop = ALU_SUB;
                    end else begin
                        aluop = funct3;
                    end
                    next_state = FETCH1;
                end
                LUI: begin
                    regfilemux_sel = RF_U;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    next_state     = FETCH1;
                end
                AUIPC: begin
                    alumux1_sel  = A1_PC;
                    alumux2_sel  = A2_U;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    next_state   = FETCH1;
                end
                BR: begin
                    alumux1_sel = A1_PC;
                    alumux2_sel = A2_B;
                    load_pc     = 1'b1;
                    pcmux_sel   = br_en ? PC_ALU : PC_PLUS4;
                    next_state  = FETCH1;
                end
                JAL, JALR: begin
                    regfilemux_sel = RF_PC4;
                    load_regfile   = 1'b1;
                    alumux1_sel    = (state == JAL) ? A1_PC : A1_RS1;
                    alumux2_sel    = (state == JAL) ? A2_J : A2_I;
                    pcmux_sel      = PC_ALU;
                    load_pc        = 1'b1;
                    next_state     = FETCH1;
                end
                CALC_ADDR: begin
                    marmux_sel = MAR_ALU;
                    load_mar   = 1'b1;
                    if (opcode == OP_STORE) begin
                        alumux2_sel   = A2_S;
                        load_data_out = 1'b1;
                        next_state    = ST1;
                    end else begin
                        next_state = LD1;
                    end
                end
                LD1: begin
                    mem.mem_read = 1'b1;
                    load_mdr     = 1'b1;
                    if (mem.mem_resp) next_state = LD2;
                end
                LD2: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    case (funct3)
                        3'b000:  regfilemux_sel = RF_LB;
                        3'b001:  regfilemux_sel = RF_LH;
                        3'b100:  regfilemux_sel = RF_LBU;
                        3'b101:  regfilemux_sel = RF_LHU;
                        default: regfilemux_sel = RF_LW;
                    endcase
                    next_state = FETCH1;
                end
                ST1: begin
                    mem.mem_write = 1'b1;
                    case (funct3)
                        3'b000:  mem.mem_byte_enable = 4'b0001 << mem.mem_addr_lo;
                        3'b001:  mem.mem_byte_enable = 4'b0011 << mem.mem_addr_lo;
                        default: mem.mem_byte_enable = 4'b1111;
                    endcase
                    if (mem.mem_resp) next_state = ST2;
                end
                ST2: begin
                    load_pc    = 1'b1;
                    next_state = FETCH1;
                end
                default: next_state = FETCH1;
            endcase
        end
    end
endmodule

// File: doc/rv32i_control.md
RV32I_CONTROL -- requirements
Module: control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  rv32i_opcode from the datapath instruction register.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7  input  7  instruction funct7.
REQ-007 br_en  input  1  comparator result from the datapath.
REQ-008 mem_addr_lo  input  2  mem_address[1:0] from the datapath.
REQ-009 mem_resp  input  1  memory completion pulse.
REQ-010 load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  output  1 each  datapath register enables.
REQ-011 pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, marmux_sel, cmpmux_sel  output  enum  datapath mux selects.
REQ-012 aluop  output  alu_ops  ALU operation.
REQ-013 cmpop  output  branch_funct3_t  comparator operation.
REQ-014 mem_read, mem_write  output  1 each  memory requests.
REQ-015 mem_byte_enable  output  4  write byte mask.

Function
REQ-016 Outputs SHALL be combinational from state and inputs; each state's outputs are listed below.
- Defaults: all loads 0, mem_read/mem_write 0, mem_byte_enable 4'b1111.
- Defaults: pcmux pc_plus4, alumux1 rs1_out, alumux2 i_imm, regfilemux alu_out, marmux pc_out, cmpmux rs2_out.
- Defaults: aluop alu_add, cmpop = funct3.
REQ-017 States SHALL be: FETCH1, FETCH2, FETCH3, DECODE, IMM, REG, LUI, AUIPC, BR, JAL, JALR, CALC_ADDR, LD1, LD2, ST1, ST2.
REQ-018 FETCH1: load_mar=1 (marmux pc_out) -> FETCH2.
REQ-019 FETCH2: mem_read=1, load_mdr=1. Hold state until mem_resp=1, then -> FETCH3.
REQ-020 FETCH3: load_ir=1 -> DECODE.
REQ-021 DECODE: no loads. Dispatch on opcode: op_imm->IMM, op_reg->REG, op_lui->LUI, op_auipc->AUIPC, op_br->BR, op_jal->JAL, op_jalr->JALR, op_load/op_store->CALC_ADDR. Any other opcode -> FETCH1.
REQ-022 IMM: load_regfile=1, load_pc=1.
- slt/sltu: cmpmux i_imm, cmpop blt/bltu, regfilemux br_en.
- sr with funct7[5]=1: aluop alu_sra.
- Otherwise aluop = funct3.
- Then -> FETCH1.
REQ-023 REG: as IMM with alumux2 rs2_out and cmpmux rs2_out.
- add with funct7[5]=1: aluop alu_sub.
- sr with funct7[5]=1: aluop alu_sra.
- Then -> FETCH1.
REQ-024 LUI: regfilemux u_imm, load_regfile=1, load_pc=1 -> FETCH1.
REQ-025 AUIPC: alumux1 pc_out, alumux2 u_imm, load_regfile=1, load_pc=1 -> FETCH1.
REQ-026 BR: alumux1 pc_out, alumux2 b_imm, load_pc=1, pcmux = alu_out if br_en else pc_plus4 -> FETCH1.
REQ-027 JAL: regfilemux pc_plus4, load_regfile=1, alumux1 pc_out, alumux2 j_imm, pcmux alu_out, load_pc=1 -> FETCH1.
REQ-028 JALR: as JAL but alumux1 rs1_out, alumux2 i_imm -> FETCH1. Bit 0 clearing is the datapath's job.
REQ-029 CALC_ADDR: marmux alu_out, load_mar=1.
- load: alumux2 i_imm -> LD1.
- store: alumux2 s_imm, load_data_out=1 -> ST1.
REQ-030 LD1: mem_read=1, load_mdr=1. Hold until mem_resp, then -> LD2.
REQ-031 LD2: load_regfile=1, load_pc=1, regfilemux by funct3 (lb/lh/lw/lbu/lhu) -> FETCH1.
REQ-032 ST1: mem_write=1. mem_byte_enable:
- sw: 4'b1111.
- sh: 4'b0011<<mem_addr_lo.
- sb: 4'b0001<<mem_addr_lo.
- Hold until mem_resp, then -> ST2.
REQ-033 ST2: load_pc=1 -> FETCH1.
REQ-034 mem_read and mem_write SHALL never both be 1. Neither SHALL be asserted outside FETCH2/LD1/ST1.
REQ-035 A mem_resp arriving in any state other than FETCH2/LD1/ST1 SHALL be ignored.
REQ-036 Writes to rd=0 are not filtered here; the register file discards them.

Reset
REQ-037 rst=0 SHALL force state to FETCH1 immediately, asynchronously, including mid-memory-wait.
REQ-038 While rst=0, all outputs SHALL hold default values with load_mar=0.
REQ-039 After rst releases, the first rising edge SHALL execute FETCH1.

Verification
REQ-040 Reset release, memory returns addi x1,x0,5 after 2 wait cycles -> FETCH1,FETCH2x3,FETCH3,DECODE,IMM. load_regfile=1 in IMM. 7 cycles total.
REQ-041 sub x3,x1,x2 (funct7=0x20) -> REG asserts aluop alu_sub, alumux2 rs2_out.
REQ-042 beq with br_en=1, then with br_en=0 -> BR pcmux alu_out, then pc_plus4. load_pc=1 in both.
REQ-043 sb at mem_addr_lo=2'b10 -> ST1 mem_byte_enable 4'b0100, mem_write held until mem_resp, then ST2 -> FETCH1.
REQ-044 rst asserted during LD1 -> state FETCH1 and mem_read=0 before the next clock edge. After release, fetch restarts.
REQ-045 Undefined opcode 7'b0000000 -> DECODE -> FETCH1. No load_regfile, load_pc or mem_write asserted.
